// File: rtl/conv11_input_buffer_mc.sv
// Ping-pong input buffer for the 1x1 conv datapath: gathers IN_CH serial channel
// samples per pixel into one of two banks and pops a whole pixel as a parallel vector.
module conv11_input_buffer_mc #(
   parameter int DATA_WIDTH = 8,
   parameter int IN_CH      = 4
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        input_valid,
   output logic                                        input_ready,
   input  logic [DATA_WIDTH-1:0]                       data_in,
   input  logic                                        inputbuf_read_en,
   output logic                                        inputbuf_load,
   output logic [DATA_WIDTH*IN_CH-1:0]                 out_vec,
   output logic                                        out_valid,
   output logic [((IN_CH > 1) ? $clog2(IN_CH) : 1)-1:0] wr_ch
);

   localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
   localparam int VW = DATA_WIDTH * IN_CH;
   localparam logic [CW-1:0] LAST_CH = CW'(IN_CH - 1);

   logic [1:0][VW-1:0] bank_q, bank_d;
   logic [VW-1:0]      out_vec_q, out_vec_d;
   logic               out_valid_q, out_valid_d;
   logic [CW-1:0]      wr_ch_q, wr_ch_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [1:0]         full_q, full_d;
   logic               accept, pop;

   // Ready/load come from registered flags only, so a bank freed by a pop is
   // writable one cycle later.
   assign input_ready   = ~full_q[wr_bank_q];
   assign inputbuf_load = full_q[rd_bank_q];
   assign accept        = input_valid & input_ready;
   assign pop           = inputbuf_read_en & inputbuf_load;

   assign out_vec   = out_vec_q;
   assign out_valid = out_valid_q;
   assign wr_ch     = wr_ch_q;

   always_comb begin
      bank_d      = bank_q;
      out_vec_d   = out_vec_q;
      out_valid_d = 1'b0;
      wr_ch_d     = wr_ch_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      full_d      = full_q;

      if (accept) begin
         for (int unsigned c = 0; c < IN_CH; c++) begin
            if (wr_ch_q == CW'(c))
               bank_d[wr_bank_q][c*DATA_WIDTH +: DATA_WIDTH] = data_in;
         end
         if (wr_ch_q == LAST_CH) begin
            wr_ch_d           = '0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_ch_d = wr_ch_q + CW'(1);
         end
      end

      // Accept needs an empty write bank and pop a full read bank, so the two
      // never touch the same full flag on one edge.
      if (pop) begin
         out_vec_d         = bank_q[rd_bank_q];
         out_valid_d       = 1'b1;
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_q      <= '0;
         out_vec_q   <= '0;
         out_valid_q <= 1'b0;
         wr_ch_q     <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= '0;
      end else begin
         bank_q      <= bank_d;
         out_vec_q   <= out_vec_d;
         out_valid_q <= out_valid_d;
         wr_ch_q     <= wr_ch_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
      end
   end

endmodule

// File: tb/tb_conv11_input_buffer_mc.sv
// Directed bench for conv11_input_buffer_mc: a 4x8-bit instance and a 1x16-bit instance.
module tb_conv11_input_buffer_mc;

   logic clk;
   logic rst;

   logic        a_valid, a_ready, a_rd, a_load, a_ov;
   logic [7:0]  a_data;
   logic [31:0] a_vec;
   logic [1:0]  a_wrch;

   logic        b_valid, b_ready, b_rd, b_load, b_ov;
   logic [15:0] b_data;
   logic [15:0] b_vec;
   logic [0:0]  b_wrch;

   int errors = 0;
   int checks = 0;

   conv11_input_buffer_mc #(.DATA_WIDTH(8), .IN_CH(4)) dut_a (
      .clk(clk), .rst(rst),
      .input_valid(a_valid), .input_ready(a_ready), .data_in(a_data),
      .inputbuf_read_en(a_rd), .inputbuf_load(a_load),
      .out_vec(a_vec), .out_valid(a_ov), .wr_ch(a_wrch)
   );

   conv11_input_buffer_mc #(.DATA_WIDTH(16), .IN_CH(1)) dut_b (
      .clk(clk), .rst(rst),
      .input_valid(b_valid), .input_ready(b_ready), .data_in(b_data),
      .inputbuf_read_en(b_rd), .inputbuf_load(b_load),
      .out_vec(b_vec), .out_valid(b_ov), .wr_ch(b_wrch)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] d);
      a_valid = 1'b1;
      a_data  = d;
      tick();
      a_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_valid = 1'b0; a_data = '0; a_rd = 1'b0;
      b_valid = 1'b0; b_data = '0; b_rd = 1'b0;
      tick();
      tick();
      #2 rst = 1'b0;
      tick();

      // reset state
      chk("rst_ready",  a_ready, 1);
      chk("rst_load",   a_load,  0);
      chk("rst_wrch",   a_wrch,  0);
      chk("rst_vec",    a_vec,   0);
      chk("rst_ov",     a_ov,    0);

      // one pixel
      send_a(8'h11);
      chk("t1_wrch1", a_wrch, 1);
      send_a(8'h22);
      send_a(8'h33);
      chk("t1_load_partial", a_load, 0);
      chk("t1_wrch3", a_wrch, 3);
      send_a(8'h44);
      chk("t1_load", a_load, 1);
      chk("t1_wrch_wrap", a_wrch, 0);
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      chk("t1_vec", a_vec, 32'h44332211);
      chk("t1_ov",  a_ov,  1);
      chk("t1_load_after", a_load, 0);
      tick();
      chk("t1_ov_pulse", a_ov, 0);
      chk("t1_vec_hold", a_vec, 32'h44332211);

      // fill both banks
      for (int i = 1; i <= 8; i++) begin
         send_a(8'(i));
         if (i == 7) chk("t2_ready_before_full", a_ready, 1);
      end
      chk("t2_ready_full", a_ready, 0);
      chk("t2_load_full",  a_load,  1);
      a_valid = 1'b1;
      a_data  = 8'hAA;
      tick();
      chk("t2_blocked_wrch", a_wrch, 0);
      chk("t2_blocked_ready", a_ready, 0);
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      chk("t2_pop_vec", a_vec, 32'h04030201);
      chk("t2_pop_ov",  a_ov,  1);
      chk("t2_ready_freed", a_ready, 1);
      chk("t2_not_yet_accepted", a_wrch, 0);
      tick();
      a_valid = 1'b0;
      chk("t2_aa_accepted", a_wrch, 1);
      chk("t2_ov_low", a_ov, 0);

      // drain bank holding 05..08, then read while empty
      a_rd = 1'b1;
      tick();
      chk("t3_pop_vec", a_vec, 32'h08070605);
      chk("t3_load_empty", a_load, 0);
      tick();
      a_rd = 1'b0;
      chk("t3_empty_ov",  a_ov,  0);
      chk("t3_empty_vec", a_vec, 32'h08070605);

      // complete AA pixel, then concurrent accept+pop
      send_a(8'hBB);
      send_a(8'hCC);
      send_a(8'hDD);
      chk("t4_load", a_load, 1);
      send_a(8'h10);
      send_a(8'h20);
      send_a(8'h30);
      chk("t4_wrch3", a_wrch, 3);
      a_valid = 1'b1;
      a_data  = 8'h40;
      a_rd    = 1'b1;
      tick();
      a_valid = 1'b0;
      a_rd    = 1'b0;
      chk("t4_conc_vec",  a_vec,  32'hDDCCBBAA);
      chk("t4_conc_ov",   a_ov,   1);
      chk("t4_conc_load", a_load, 1);
      chk("t4_conc_wrch", a_wrch, 0);
      chk("t4_conc_ready", a_ready, 1);
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      chk("t4_second_vec", a_vec, 32'h40302010);
      chk("t4_second_load", a_load, 0);

      // async reset mid-pixel (between edges)
      send_a(8'h55);
      send_a(8'h66);
      chk("t5_wrch_pre", a_wrch, 2);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_wrch", a_wrch, 0);
      chk("t5_rst_load", a_load, 0);
      chk("t5_rst_vec",  a_vec,  0);
      #1 rst = 1'b0;
      tick();
      chk("t5_ready", a_ready, 1);
      send_a(8'hA1);
      send_a(8'hB2);
      send_a(8'hC3);
      send_a(8'hD4);
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
      chk("t5_clean_vec", a_vec, 32'hD4C3B2A1);

      // IN_CH = 1, 16-bit
      chk("t6_rst_ready", b_ready, 1);
      chk("t6_rst_vec", b_vec, 0);
      b_valid = 1'b1;
      b_data  = 16'h1234;
      tick();
      chk("t6_load1", b_load, 1);
      chk("t6_ready1", b_ready, 1);
      chk("t6_wrch", b_wrch, 0);
      b_data = 16'hBEEF;
      tick();
      b_valid = 1'b0;
      chk("t6_ready_full", b_ready, 0);
      tick();
      chk("t6_ready_hold", b_ready, 0);
      b_rd = 1'b1;
      tick();
      chk("t6_pop1", b_vec, 16'h1234);
      chk("t6_ov1", b_ov, 1);
      chk("t6_ready_freed", b_ready, 1);
      tick();
      b_rd = 1'b0;
      chk("t6_pop2", b_vec, 16'hBEEF);
      chk("t6_ov2", b_ov, 1);
      chk("t6_load_empty", b_load, 0);
      tick();
      chk("t6_ov_off", b_ov, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
